fadd_ctrl: RTL and testbench

FADD_CTRL -- requirements
Module: fadd_ctrl

---
 rtl/fadd_ctrl.sv | 155 +++++++++++++++
 tb/tb_fadd_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_ctrl.sv
// Floating-point adder sequencer: load, align, add, normalise, pack.
// Latency: start edge to done = 5 + align_cnt + (NORM cycles - 1); special operands take 3 cycles.
// Backpressure: none; start is accepted only in IDLE, and any start while busy is dropped.
//
// Ports:
//   clk, res                         clock, asynchronous active-low reset
//   start, exp_a, exp_b              operation request and biased operand exponents (sampled in IDLE)
//   special                          NaN/Inf/zero operand flag from the datapath (sampled in LOAD)
//   sum_carry, sum_lead, sum_zero    mantissa-sum status flags (used in NORM)
//   busy, done, swap                 status, one-cycle completion pulse, larger-operand mux select
//   ld_op, align_shift, add_en,
//   norm_r, norm_l, pack_en, bypass  datapath strobes
module fadd_ctrl (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [7:0] exp_a,
  input  logic [7:0] exp_b,
  input  logic       special,
  input  logic       sum_carry,
  input  logic       sum_lead,
  input  logic       sum_zero,
  output logic       busy,
  output logic       done,
  output logic       swap,
  output logic       ld_op,
  output logic       align_shift,
  output logic       add_en,
  output logic       norm_r,
  output logic       norm_l,
  output logic       pack_en,
  output logic       bypass
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ALIGN = 3'd2,
    S_ADD   = 3'd3,
    S_NORM  = 3'd4,
    S_PACK  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // A 24-bit mantissa plus guard position is fully shifted out after 25 steps,
  // so larger exponent differences saturate here.
  localparam logic [4:0] ALIGN_MAX = 5'd25;
  // Left shifts needed to bring bit 0 of the sum up to the hidden-bit position.
  localparam logic [4:0] NORM_MAX  = 5'd23;

  state_t     state_q, state_d;
  logic [4:0] align_cnt_q, align_cnt_d;
  logic [4:0] norm_cnt_q, norm_cnt_d;
  logic       swap_q, swap_d;
  logic       byp_q, byp_d;
  logic [7:0] exp_diff;
  logic       norm_exit;

  always_comb begin
    exp_diff = (exp_b > exp_a) ? (exp_b - exp_a) : (exp_a - exp_b);
  end

  // Carry takes priority: it forces a single right shift and leaves NORM even
  // if lead/zero are also reported in the same cycle.
  always_comb begin
    norm_exit = sum_carry | sum_lead | sum_zero | (norm_cnt_q == NORM_MAX);
  end

  always_comb begin
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    norm_cnt_d  = norm_cnt_q;
    swap_d      = swap_q;
    byp_d       = byp_q;
    case (state_q)
      S_IDLE: begin
        swap_d = 1'b0;
        byp_d  = 1'b0;
        if (start) begin
          state_d     = S_LOAD;
          swap_d      = (exp_b > exp_a);
          align_cnt_d = (exp_diff > 8'(ALIGN_MAX)) ? ALIGN_MAX : exp_diff[4:0];
        end
      end
      S_LOAD: begin
        if (special) begin
          state_d = S_PACK;
          byp_d   = 1'b1;
        end else if (align_cnt_q == 5'd0) begin
          state_d = S_ADD;
        end else begin
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        align_cnt_d = align_cnt_q - 5'd1;
        if (align_cnt_q <= 5'd1) begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        norm_cnt_d = 5'd0;
        state_d    = S_NORM;
      end
      S_NORM: begin
        if (norm_exit) begin
          state_d = S_PACK;
        end else begin
          norm_cnt_d = norm_cnt_q + 5'd1;
        end
      end
      S_PACK: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        byp_d   = 1'b0;
        swap_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= S_IDLE;
      align_cnt_q <= 5'd0;
      norm_cnt_q  <= 5'd0;
      swap_q      <= 1'b0;
      byp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
      norm_cnt_q  <= norm_cnt_d;
      swap_q      <= swap_d;
      byp_q       <= byp_d;
    end
  end

  // Everything except the normalise strobes decodes registered state only.
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign swap        = swap_q;
  assign ld_op       = (state_q == S_LOAD);
  assign align_shift = (state_q == S_ALIGN);
  assign add_en      = (state_q == S_ADD);
  assign pack_en     = (state_q == S_PACK);
  assign bypass      = (state_q == S_PACK) & byp_q;
  assign norm_r      = (state_q == S_NORM) & sum_carry;
  assign norm_l      = (state_q == S_NORM) & ~sum_carry & ~sum_lead & ~sum_zero &
                       (norm_cnt_q < NORM_MAX);

endmodule

// File: tb/tb_fadd_ctrl.sv
// Directed bench for fadd_ctrl: each task drives one scenario and checks it inline.
// Cycle n = 1 is the cycle right after the edge that samples start.
// Inputs change 1 time unit after a rising edge, outputs are sampled 2 units after.
module tb_fadd_ctrl;

  logic       clk;
  logic       res;
  logic       start;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic       special;
  logic       sum_carry;
  logic       sum_lead;
  logic       sum_zero;
  logic       busy, done, swap, ld_op, align_shift, add_en;
  logic       norm_r, norm_l, pack_en, bypass;

  int n_checks = 0;
  int n_fail   = 0;

  // Results collected by run_op
  int   r_done_cyc, r_align, r_nl, r_nr, r_add, r_pack, r_byp, r_ld;
  logic r_swap_load, r_swap_done, r_done_after, r_busy_after;

  fadd_ctrl dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .exp_a      (exp_a),
    .exp_b      (exp_b),
    .special    (special),
    .sum_carry  (sum_carry),
    .sum_lead   (sum_lead),
    .sum_zero   (sum_zero),
    .busy       (busy),
    .done       (done),
    .swap       (swap),
    .ld_op      (ld_op),
    .align_shift(align_shift),
    .add_en     (add_en),
    .norm_r     (norm_r),
    .norm_l     (norm_l),
    .pack_en    (pack_en),
    .bypass     (bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full operation. sum_lead rises once lead_after norm_l pulses have been seen;
  // a spurious start is pulsed in cycle restart_at (0 = never).
  task automatic run_op(input logic [7:0] ea, input logic [7:0] eb, input logic sp,
                        input logic cy, input logic zr, input int lead_after,
                        input int restart_at);
    r_done_cyc = -1; r_align = 0; r_nl = 0; r_nr = 0; r_add = 0;
    r_pack = 0; r_byp = 0; r_ld = 0; r_swap_load = 1'b0; r_swap_done = 1'b0;
    @(posedge clk); #1;
    exp_a = ea; exp_b = eb; special = sp; sum_carry = cy; sum_zero = zr;
    sum_lead = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      start    = (n == restart_at);
      sum_lead = (r_nl >= lead_after);
      #1;
      if (n == 1) r_swap_load = swap;
      r_align += int'(align_shift);
      r_nl    += int'(norm_l);
      r_nr    += int'(norm_r);
      r_add   += int'(add_en);
      r_pack  += int'(pack_en);
      r_byp   += int'(bypass);
      r_ld    += int'(ld_op);
      if (done === 1'b1) begin
        r_done_cyc  = n;
        r_swap_done = swap;
        break;
      end
    end
    start = 1'b0;
    @(posedge clk); #2;
    r_done_after = done;
    r_busy_after = busy;
    special = 1'b0; sum_carry = 1'b0; sum_lead = 1'b0; sum_zero = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    res = 1'b0; start = 1'b0; exp_a = 8'h00; exp_b = 8'h00;
    special = 1'b0; sum_carry = 1'b0; sum_lead = 1'b0; sum_zero = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    outs = {busy, done, swap, ld_op, align_shift, add_en, norm_r, norm_l, pack_en, bypass};
    n_checks++;
    if (outs !== 10'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected %b", outs, 10'b0);
    end
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #2;
    outs = {busy, done, swap, ld_op, align_shift, add_en, norm_r, norm_l, pack_en, bypass};
    n_checks++;
    if (outs !== 10'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected %b", outs, 10'b0);
    end
  endtask

  task automatic test_basic_carry();
    run_op(8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 99, 0);
    n_checks++;
    if (r_done_cyc !== 5) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 5", r_done_cyc); end
    n_checks++;
    if (r_align !== 0) begin n_fail++; $display("FAIL basic_align: got %0d expected 0", r_align); end
    n_checks++;
    if (r_nr !== 1) begin n_fail++; $display("FAIL basic_norm_r: got %0d expected 1", r_nr); end
    n_checks++;
    if (r_nl !== 0) begin n_fail++; $display("FAIL basic_norm_l: got %0d expected 0", r_nl); end
    n_checks++;
    if (r_add !== 1 || r_pack !== 1 || r_ld !== 1) begin
      n_fail++; $display("FAIL basic_strobes: add %0d pack %0d ld %0d expected 1 1 1", r_add, r_pack, r_ld);
    end
    n_checks++;
    if (r_byp !== 0) begin n_fail++; $display("FAIL basic_bypass: got %0d expected 0", r_byp); end
    n_checks++;
    if (r_swap_done !== 1'b0) begin n_fail++; $display("FAIL basic_swap: got %b expected 0", r_swap_done); end
    n_checks++;
    if (r_done_after !== 1'b0 || r_busy_after !== 1'b0) begin
      n_fail++; $display("FAIL basic_after_done: done %b busy %b expected 0 0", r_done_after, r_busy_after);
    end
  endtask

  task automatic test_align_small();
    run_op(8'h7F, 8'h82, 1'b0, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (r_done_cyc !== 8) begin n_fail++; $display("FAIL align3_done_cycle: got %0d expected 8", r_done_cyc); end
    n_checks++;
    if (r_align !== 3) begin n_fail++; $display("FAIL align3_shifts: got %0d expected 3", r_align); end
    n_checks++;
    if (r_swap_load !== 1'b1 || r_swap_done !== 1'b1) begin
      n_fail++; $display("FAIL align3_swap: load %b done %b expected 1 1", r_swap_load, r_swap_done);
    end
    n_checks++;
    if (r_nl !== 0 || r_nr !== 0) begin
      n_fail++; $display("FAIL align3_norm: l %0d r %0d expected 0 0", r_nl, r_nr);
    end
  endtask

  task automatic test_align_saturate();
    run_op(8'h10, 8'h38, 1'b0, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (r_align !== 25) begin n_fail++; $display("FAIL align_sat_shifts: got %0d expected 25", r_align); end
    n_checks++;
    if (r_swap_done !== 1'b1) begin n_fail++; $display("FAIL align_sat_swap: got %b expected 1", r_swap_done); end
    n_checks++;
    if (r_done_cyc !== 30) begin n_fail++; $display("FAIL align_sat_done_cycle: got %0d expected 30", r_done_cyc); end
  endtask

  task automatic test_special();
    run_op(8'h90, 8'h40, 1'b1, 1'b0, 1'b0, 0, 0);
    n_checks++;
    if (r_done_cyc !== 3) begin n_fail++; $display("FAIL special_done_cycle: got %0d expected 3", r_done_cyc); end
    n_checks++;
    if (r_align !== 0 || r_add !== 0) begin
      n_fail++; $display("FAIL special_skip: align %0d add %0d expected 0 0", r_align, r_add);
    end
    n_checks++;
    if (r_pack !== 1 || r_byp !== 1) begin
      n_fail++; $display("FAIL special_pack: pack %0d bypass %0d expected 1 1", r_pack, r_byp);
    end
    n_checks++;
    if (r_swap_done !== 1'b0) begin n_fail++; $display("FAIL special_swap: got %b expected 0", r_swap_done); end
  endtask

  task automatic test_normalise();
    // Lead bit appears after five left shifts
    run_op(8'h55, 8'h55, 1'b0, 1'b0, 1'b0, 5, 0);
    n_checks++;
    if (r_nl !== 5) begin n_fail++; $display("FAIL norm5_pulses: got %0d expected 5", r_nl); end
    n_checks++;
    if (r_done_cyc !== 10) begin n_fail++; $display("FAIL norm5_done_cycle: got %0d expected 10", r_done_cyc); end
    // Zero sum leaves after one NORM cycle with no shift
    run_op(8'h55, 8'h55, 1'b0, 1'b0, 1'b1, 99, 0);
    n_checks++;
    if (r_nl !== 0 || r_done_cyc !== 5) begin
      n_fail++; $display("FAIL norm_zero: norm_l %0d done_cycle %0d expected 0 5", r_nl, r_done_cyc);
    end
    // Lead never rises: shifting stops at the limit
    run_op(8'h55, 8'h55, 1'b0, 1'b0, 1'b0, 99, 0);
    n_checks++;
    if (r_nl !== 23) begin n_fail++; $display("FAIL norm_limit_pulses: got %0d expected 23", r_nl); end
    n_checks++;
    if (r_done_cyc !== 28) begin n_fail++; $display("FAIL norm_limit_done_cycle: got %0d expected 28", r_done_cyc); end
    // Carry together with lead and zero: one right shift, no left shift
    run_op(8'h55, 8'h55, 1'b0, 1'b1, 1'b1, 0, 0);
    n_checks++;
    if (r_nr !== 1 || r_nl !== 0 || r_done_cyc !== 5) begin
      n_fail++; $display("FAIL norm_carry_priority: r %0d l %0d done_cycle %0d expected 1 0 5", r_nr, r_nl, r_done_cyc);
    end
  endtask

  task automatic test_reset_mid_align();
    logic [9:0] outs;
    int         extra_done;
    @(posedge clk); #1;
    exp_a = 8'h10; exp_b = 8'h1A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (align_shift !== 1'b1) begin n_fail++; $display("FAIL midalign_in_align: got %b expected 1", align_shift); end
    res = 1'b0;
    #1;
    outs = {busy, done, swap, ld_op, align_shift, add_en, norm_r, norm_l, pack_en, bypass};
    n_checks++;
    if (outs !== 10'b0) begin n_fail++; $display("FAIL midalign_async_clear: got %b expected %b", outs, 10'b0); end
    extra_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #2;
      extra_done += int'(done);
      if (i == 5) res = 1'b1;
    end
    n_checks++;
    if (extra_done !== 0) begin n_fail++; $display("FAIL midalign_no_done: got %0d done pulses expected 0", extra_done); end
    run_op(8'h80, 8'h80, 1'b0, 1'b1, 1'b0, 99, 0);
    n_checks++;
    if (r_done_cyc !== 5) begin n_fail++; $display("FAIL post_reset_start: got %0d expected 5", r_done_cyc); end
  endtask

  task automatic test_back_to_back();
    int extra_done;
    run_op(8'h7F, 8'h82, 1'b0, 1'b0, 1'b0, 0, 3);
    n_checks++;
    if (r_done_cyc !== 8) begin n_fail++; $display("FAIL busy_start_done_cycle: got %0d expected 8", r_done_cyc); end
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      extra_done += int'(done) + int'(busy);
    end
    n_checks++;
    if (extra_done !== 0) begin n_fail++; $display("FAIL busy_start_ignored: got %0d busy/done cycles expected 0", extra_done); end
  endtask

  initial begin
    test_reset();
    test_basic_carry();
    test_align_small();
    test_align_saturate();
    test_special();
    test_normalise();
    test_reset_mid_align();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
